// File: rtl/vblank_board_arbiter.sv
// vblank_board_arbiter: board RAM port sharing; renderer reads win, game writes queue and commit in vblank.
// Optional ARB_HBLANK_WR_EN also commits queued writes during horizontal blanking.
module vblank_board_arbiter #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 2,
  parameter int FIFO_AW      = 2,
  parameter int VBLANK_START = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        CounterY,
  input  logic              inDisplayArea,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [FIFO_AW:0]  fifo_level,
  output logic              frame_tick,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic {ACTIVE, VBLANK} state_t;
  localparam logic [9:0]         VB_ROW  = 10'(VBLANK_START);
  localparam logic [FIFO_AW:0]   DEPTH   = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   LVL_ONE = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
  state_t state_q, state_d;
  logic frame_tick_q, frame_tick_d;
  logic rd_valid_q;
  logic [FIFO_AW:0] level_q, level_d;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W+DATA_W-1:0] fifo_q [2**FIFO_AW];
  logic [ADDR_W-1:0] addr_q, head_addr;
  logic [DATA_W-1:0] wdata_q, head_data;
  logic push, grant, win;
  always_comb begin
    state_d      = state_q;
    frame_tick_d = 1'b0;
    if (state_q == ACTIVE && CounterY >= VB_ROW) begin
      state_d      = VBLANK;
      frame_tick_d = 1'b1;
    end
    if (state_q == VBLANK && CounterY < VB_ROW)
      state_d = ACTIVE;
  end
`ifdef ARB_HBLANK_WR_EN
  assign win = (state_q == VBLANK) || !inDisplayArea;
`else
  logic unused_in_display;
  assign unused_in_display = inDisplayArea;
  assign win = (state_q == VBLANK);
`endif
  assign {head_addr, head_data} = fifo_q[rd_ptr_q];
  assign wr_ready   = level_q < DEPTH;
  assign push       = wr_valid && wr_ready;
  assign grant      = (level_q != '0) && !rd_req && win;
  assign fifo_level = level_q;
  assign frame_tick = frame_tick_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = mem_rdata;
  assign mem_en     = rd_req || grant;
  assign mem_we     = grant;
  assign mem_addr   = rd_req ? rd_addr : grant ? head_addr : addr_q;
  assign mem_wdata  = grant ? head_data : wdata_q;
  always_comb
    level_d = (push && !grant) ? level_q + LVL_ONE :
              (grant && !push) ? level_q - LVL_ONE : level_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACTIVE;
      frame_tick_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      level_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      frame_tick_q <= frame_tick_d;
      rd_valid_q   <= rd_req;
      level_q      <= level_d;
      wr_ptr_q     <= push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_q     <= grant ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      addr_q       <= mem_addr;
      wdata_q      <= mem_wdata;
    end
  end
  always_ff @(posedge clk)
    if (push) fifo_q[wr_ptr_q] <= {wr_addr, wr_data};
endmodule

// File: tb/tb_vblank_board_arbiter.sv
// tb_vblank_board_arbiter: directed stimulus with a scoreboard of expected RAM writes and read data.
module tb_vblank_board_arbiter;
  logic       clk, reset, inDisplayArea, rd_req, rd_valid, wr_valid, wr_ready, frame_tick;
  logic       mem_en, mem_we;
  logic [9:0] CounterY;
  logic [5:0] rd_addr, wr_addr, mem_addr;
  logic [1:0] rd_data, wr_data, mem_wdata, mem_rdata;
  logic [2:0] fifo_level;
  logic [1:0] ram [64];
  logic [7:0] exp_wr [$];
  logic [1:0] exp_rd [$];
  logic       allow_wr;
  int checks = 0, errors = 0;

  vblank_board_arbiter dut (
    .clk(clk), .reset(reset), .CounterY(CounterY), .inDisplayArea(inDisplayArea),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .fifo_level(fifo_level), .frame_tick(frame_tick), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 2'd0;
    mem_rdata = 2'd0;
  end
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  always @(negedge clk)
    if (!reset) begin
      if (mem_en && mem_we) begin
        if (!allow_wr || exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0d at t=%0t", mem_addr, mem_wdata, $time);
        end else chk("write_order", {mem_addr, mem_wdata}, exp_wr.pop_front());
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rd_valid: data %0d", rd_data);
        end else chk("read_data", rd_data, exp_rd.pop_front());
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] a, input logic [1:0] d, input bit accepted);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    if (accepted) exp_wr.push_back({a, d});
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; CounterY = 10'd0; inDisplayArea = 1'b1; rd_req = 1'b0; rd_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; allow_wr = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("reset_level", fifo_level, 0);
    chk("reset_wr_ready", wr_ready, 1);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_frame_tick", frame_tick, 0);
    chk("reset_mem_en", mem_en, 0);
    reset = 1'b0; CounterY = 10'd100;
    push(6'd11, 2'd1, 0); push(6'd12, 2'd2, 0); push(6'd13, 2'd1, 0);
    @(negedge clk);
    chk("queued_before_reset", fifo_level, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("level_after_reset", fifo_level, 0);
    chk("ready_after_reset", wr_ready, 1);
    push(6'd1, 2'd1, 1); push(6'd2, 2'd2, 1); push(6'd3, 2'd1, 1); push(6'd4, 2'd2, 1);
    @(negedge clk);
    chk("full_level", fifo_level, 4);
    chk("full_not_ready", wr_ready, 0);
    push(6'd7, 2'd3, 0);
    @(negedge clk);
    chk("fifth_rejected", fifo_level, 4);
    repeat (5) tick();
    CounterY = 10'd479;
    tick();
    @(negedge clk);
    chk("tick_low_479", frame_tick, 0);
    CounterY = 10'd480; allow_wr = 1'b1;
    tick();
    @(negedge clk);
    chk("tick_high_480", frame_tick, 1);
    chk("drain_starts", mem_we, 1);
    chk("level_before_pop", fifo_level, 4);
    tick();
    @(negedge clk);
    chk("tick_one_cycle", frame_tick, 0);
    chk("level_after_pop", fifo_level, 3);
    repeat (3) tick();
    @(negedge clk);
    chk("drained_level", fifo_level, 0);
    chk("drained_all", exp_wr.size(), 0);
    CounterY = 10'd481; allow_wr = 1'b0; rd_req = 1'b1; rd_addr = 6'd1;
    exp_rd.push_back(2'd1); push(6'd20, 2'd1, 1);
    exp_rd.push_back(2'd1); push(6'd21, 2'd2, 1);
    @(negedge clk);
    chk("vblank_level2", fifo_level, 2);
    for (int i = 1; i <= 3; i++) begin
      rd_addr = 6'(i);
      exp_rd.push_back((i == 2) ? 2'd2 : 2'd1);
      tick();
      chk("read_blocks_write", mem_we, 0);
    end
    rd_req = 1'b0; allow_wr = 1'b1;
    @(negedge clk);
    chk("write_after_read", mem_we, 1);
    chk("level_held_by_reads", fifo_level, 2);
    repeat (2) tick();
    @(negedge clk);
    chk("post_read_drain", fifo_level, 0);
    CounterY = 10'd521;
    tick();
    CounterY = 10'd0; allow_wr = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("wrap_tick_low", frame_tick, 0);
    CounterY = 10'd200;
    push(6'd5, 2'd2, 1);
    rd_req = 1'b1; rd_addr = 6'd5; exp_rd.push_back(2'd0);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    chk("active_no_drain", fifo_level, 1);
    CounterY = 10'd10; inDisplayArea = 1'b0;
`ifdef ARB_HBLANK_WR_EN
    allow_wr = 1'b1;
`endif
    push(6'd6, 2'd1, 1);
    repeat (3) tick();
    @(negedge clk);
`ifdef ARB_HBLANK_WR_EN
    chk("hblank_drain", fifo_level, 0);
`else
    chk("hblank_held", fifo_level, 2);
`endif
    CounterY = 10'd480; allow_wr = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("final_drain", fifo_level, 0);
    CounterY = 10'd0; inDisplayArea = 1'b1; allow_wr = 1'b0;
    repeat (2) tick();
    rd_req = 1'b1; rd_addr = 6'd5; exp_rd.push_back(2'd2);
    tick();
    rd_addr = 6'd6; exp_rd.push_back(2'd1);
    tick();
    rd_req = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("reads_all_seen", exp_rd.size(), 0);
    chk("writes_all_seen", exp_wr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
